if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word-aligned imem requests and presents one instruction to IF/ID.
// Latency: START then REQ after reset; a zero-wait memory then delivers one instruction per cycle.
// Backpressure: PCWrite=0 stalls the output slot. One extra response is held in a skid entry (HOLD).
//
// Ports: clk/startin (async active-high reset); PCWrite (slot consumed), PCSrc/branch_target (redirect);
//        imem_req/imem_addr/imem_ready/imem_rdata (memory handshake, transfer = req & ready);
//        IF_instr/IF_pc_plus_4/IF_valid (output slot).
// Optional: define IF_FETCH_CNT_EN to add fetch_count, a count of instructions loaded into the slot.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        startin,
    input  logic        PCWrite,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pc_plus_4,
    output logic        IF_valid
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [2:0] {START, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;   // address of the request being flushed
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
`endif

    logic        xfer;
    logic        slot_free;
    logic [31:0] pc_plus_4;

    assign imem_req     = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
    // While draining, the old address must stay on the bus even though pc already holds the target.
    assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign xfer         = imem_req & imem_ready;
    assign slot_free    = ~valid_q | PCWrite;
    assign pc_plus_4    = pc_q + 32'd4;

    assign IF_instr     = instr_q;
    assign IF_pc_plus_4 = pc4_q;
    assign IF_valid     = valid_q;
`ifdef IF_FETCH_CNT_EN
    assign fetch_count  = cnt_q;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
`ifdef IF_FETCH_CNT_EN
        cnt_d        = cnt_q;
`endif

        // A consumed slot empties unless something below reloads it this edge.
        if (PCWrite) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            START: begin
                state_d = REQ;
            end
            REQ, WAIT: begin
                if (xfer) begin
                    pc_d = pc_plus_4;
                    if (slot_free) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus_4;
                        valid_d = 1'b1;
`ifdef IF_FETCH_CNT_EN
                        cnt_d   = cnt_q + 32'd1;
`endif
                        state_d = REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus_4;
                        state_d      = HOLD;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (PCWrite) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
`ifdef IF_FETCH_CNT_EN
                    cnt_d   = cnt_q + 32'd1;
`endif
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = START;
            end
        endcase

        // Redirect overrides everything above: nothing loaded this edge survives or is counted.
        if (PCSrc) begin
            pc_d    = {branch_target[31:2], 2'b00};
            valid_d = 1'b0;
`ifdef IF_FETCH_CNT_EN
            cnt_d   = cnt_q;
`endif
            unique case (state_q)
                REQ, WAIT: begin
                    if (xfer) begin
                        state_d = REQ;
                    end else begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end
                DRAIN:   state_d = xfer ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state_q      <= START;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'd0;
            instr_q      <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
`ifdef IF_FETCH_CNT_EN
            cnt_q        <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
`ifdef IF_FETCH_CNT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios then random traffic against a transaction-level model.
// Inputs change on the falling edge; outputs are compared on the falling edge before new inputs are applied.
// The memory returns a word derived from the request address, so a wrong address shows up as wrong data.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        startin;
    logic        PCWrite;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_instr;
    logic [31:0] IF_pc_plus_4;
    logic        IF_valid;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .startin       (startin),
        .PCWrite       (PCWrite),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_instr      (IF_instr),
        .IF_pc_plus_4  (IF_pc_plus_4),
        .IF_valid      (IF_valid)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, tracked per transaction rather than per FSM state:
    // started   - first edge after reset has passed (requests allowed)
    // skid_full - an undelivered response is parked, so no request is outstanding
    // drop      - the outstanding response belongs to a cancelled fetch at drop_addr
    logic        m_started, m_skid_full, m_drop, m_valid;
    logic [31:0] m_pc, m_drop_addr, m_instr, m_pc4, m_skid_instr, m_skid_pc4, m_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = m_started && !m_skid_full;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
        chk("IF_valid", {31'd0, IF_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("IF_instr", IF_instr, m_instr);
            chk("IF_pc_plus_4", IF_pc_plus_4, m_pc4);
        end
`ifdef IF_FETCH_CNT_EN
        chk("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_skid_full = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        m_pc = 32'd0; m_drop_addr = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_skid_instr = 32'd0; m_skid_pc4 = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic model_update();
        logic        req, xfer;
        logic [31:0] raddr, tgt;
        req   = m_started && !m_skid_full;
        raddr = m_drop ? m_drop_addr : m_pc;
        xfer  = req && imem_ready;
        tgt   = branch_target & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1'b1;
            if (PCWrite) m_valid = 1'b0;
            if (PCSrc) begin m_pc = tgt; m_valid = 1'b0; end
        end else if (m_skid_full) begin
            if (PCSrc) begin
                m_pc = tgt; m_valid = 1'b0; m_skid_full = 1'b0;
            end else if (PCWrite) begin
                m_instr = m_skid_instr; m_pc4 = m_skid_pc4; m_valid = 1'b1;
                m_skid_full = 1'b0; m_cnt = m_cnt + 1;
            end
        end else if (PCSrc) begin
            if (xfer) m_drop = 1'b0;
            else if (!m_drop) begin m_drop = 1'b1; m_drop_addr = m_pc; end
            m_pc = tgt; m_valid = 1'b0;
        end else if (m_drop) begin
            if (xfer) m_drop = 1'b0;
            if (PCWrite) m_valid = 1'b0;
        end else if (xfer) begin
            if (!m_valid || PCWrite) begin
                m_instr = mem_word(raddr); m_pc4 = raddr + 32'd4; m_valid = 1'b1;
                m_cnt = m_cnt + 1;
            end else begin
                m_skid_instr = mem_word(raddr); m_skid_pc4 = raddr + 32'd4; m_skid_full = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (PCWrite) begin
            m_valid = 1'b0;
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input logic pcw, input logic pcs, input logic [31:0] tgt, input logic rdy);
        compare_all();
        PCWrite       = pcw;
        PCSrc         = pcs;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = mem_word(imem_addr);
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserted between edges so the clear must be asynchronous to be seen.
    task automatic do_reset();
        startin = 1'b1;
        PCWrite = 1'b0; PCSrc = 1'b0; branch_target = 32'd0; imem_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_IF_valid", {31'd0, IF_valid}, 32'd0);
        chk("rst_IF_instr", IF_instr, 32'd0);
        chk("rst_IF_pc_plus_4", IF_pc_plus_4, 32'd0);
`ifdef IF_FETCH_CNT_EN
        chk("rst_fetch_count", fetch_count, 32'd0);
`endif
        @(negedge clk);
        startin = 1'b0;
    endtask

    initial begin
        startin = 1'b1; PCWrite = 1'b0; PCSrc = 1'b0; branch_target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        do_reset();

        // START then REQ, then one instruction per cycle with a zero-wait memory.
        step(1, 0, 32'd0, 1);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        step(1, 0, 32'd0, 1);
        chk("first_pc4", IF_pc_plus_4, 32'd4);
        step(1, 0, 32'd0, 1);
        chk("second_pc4", IF_pc_plus_4, 32'd8);
        step(1, 0, 32'd0, 1);
        chk("third_pc4", IF_pc_plus_4, 32'd12);

        // Slow memory: address must hold through the wait states.
        repeat (3) step(1, 0, 32'd0, 0);
        step(1, 0, 32'd0, 1);

        // Stall during back-to-back fetch: one response goes to the skid entry.
        step(1, 0, 32'd0, 1);
        repeat (3) step(0, 0, 32'd0, 1);
        repeat (3) step(1, 0, 32'd0, 1);

        // Redirect while waiting: old response dropped, new address word-aligned.
        step(1, 0, 32'd0, 0);
        step(1, 1, 32'h0000_0103, 0);
        step(1, 0, 32'd0, 0);
        step(1, 0, 32'd0, 1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_valid", {31'd0, IF_valid}, 32'd0);
        step(1, 0, 32'd0, 1);
        step(1, 0, 32'd0, 1);

        // Address wrap at the top of the 32-bit space.
        step(1, 1, 32'hFFFF_FFFE, 1);
        step(1, 0, 32'd0, 1);
        chk("wrap_pc4", IF_pc_plus_4, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        step(1, 0, 32'd0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 6);
        end

        // Reset in the middle of a wait state; nothing from it may be captured afterwards.
        step(1, 0, 32'd0, 1);
        step(1, 0, 32'd0, 0);
        step(1, 0, 32'd0, 0);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 6);
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
